// File: rtl/opcode_decrypt_pipe_if.sv
// Fetch/result handshake bundle between the ROM fetch side and the opcode decryptor.
// The master drives fetch requests and accepts results; the slave is the decryptor.
interface opcode_decrypt_pipe_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_m1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_addr, in_data, in_m1, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_m1, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/opcode_decrypt_pipe.sv
// Single-stage opcode decryptor: XOR with a downloadable 8-entry key table selected by
// fetch type and two address bits, optionally followed by a fixed bit permutation.
module opcode_decrypt_pipe #(
  parameter int              DW    = 8,
  parameter int              AW    = 16,
  parameter int              BIT_A = 13,
  parameter int              BIT_B = 2,
  parameter logic [3*DW-1:0] PERM  = {3'd7, 3'd2, 3'd5, 3'd1, 3'd3, 3'd6, 3'd4, 3'd0}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  dn_start,
  input  logic                  dn_wr,
  input  logic [2:0]            dn_addr,
  input  logic [DW-1:0]         dn_data,
  output logic                  loaded,
  opcode_decrypt_pipe_if.slave  bus
);

  logic [DW-1:0] table_q [8];
  logic [DW-1:0] table_d [8];
  logic [3:0]    cnt_q, cnt_d;
  logic          loaded_q, loaded_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          in_ready;
  logic          accept;
  logic [1:0]    eff_mode;
  logic [2:0]    idx;
  logic [DW-1:0] x_val;
  logic [DW-1:0] perm_val;
  logic [DW-1:0] result;
  logic          unused_addr_parity;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Lookup reads the registered table, so a same-cycle write is seen only by later fetches.
  assign idx   = {bus.in_m1, bus.in_addr[BIT_A], bus.in_addr[BIT_B]};
  assign x_val = bus.in_data ^ table_q[idx];
  assign unused_addr_parity = ^bus.in_addr;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_perm
      assign perm_val[gi] = x_val[PERM[3*gi +: 3]];
    end
  endgenerate

  // An unloaded table would scramble fetches, so decryption is bypassed until loaded.
  always_comb begin
    eff_mode = 2'd0;
    if (loaded_q && (mode == 2'd1 || mode == 2'd2)) begin
      eff_mode = mode;
    end
    result = bus.in_data;
    case (eff_mode)
      2'd1:    result = x_val;
      2'd2:    result = perm_val;
      default: result = bus.in_data;
    endcase
  end

  always_comb begin
    table_d = table_q;
    if (dn_wr) begin
      table_d[dn_addr] = dn_data;
    end
    cnt_d = cnt_q;
    if (dn_start) begin
      cnt_d = dn_wr ? 4'd1 : 4'd0;
    end else if (dn_wr && cnt_q < 4'd8) begin
      cnt_d = cnt_q + 4'd1;
    end
    loaded_d = (cnt_d == 4'd8);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      table_q     <= '{default: '0};
      cnt_q       <= 4'd0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      table_q     <= table_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign loaded        = loaded_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_opcode_decrypt_pipe.sv
// Self-checking bench for opcode_decrypt_pipe: directed vectors, corner sequences and
// random traffic checked every cycle against a behavioural model of the key table and output slot.
module tb_opcode_decrypt_pipe;
  localparam int DW = 8;
  localparam int AW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       dn_start;
  logic       dn_wr;
  logic [2:0] dn_addr;
  logic [7:0] dn_data;
  logic       loaded;

  opcode_decrypt_pipe_if #(.DW(DW), .AW(AW)) bus ();

  opcode_decrypt_pipe #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .dn_start (dn_start),
    .dn_wr    (dn_wr),
    .dn_addr  (dn_addr),
    .dn_data  (dn_data),
    .loaded   (loaded),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Output bit i is taken from input bit perm_src[i] under the default permutation.
  int perm_src [8] = '{0, 4, 6, 3, 1, 5, 2, 7};

  logic [7:0] m_key [8];
  int         m_cnt;
  logic       m_loaded;
  logic       m_valid;
  logic [7:0] m_data;

  logic [7:0] dl_vals  [8];
  logic [2:0] dl_addrs [8];

  typedef struct {
    logic [1:0]  md;
    logic        m1;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_decrypt(input logic [1:0] md, input logic ld,
                                             input logic m1, input logic [15:0] a,
                                             input logic [7:0] d);
    int         idx;
    logic [7:0] x;
    logic [7:0] y;
    idx = (m1 ? 4 : 0) + (a[13] ? 2 : 0) + (a[2] ? 1 : 0);
    x = d ^ m_key[idx];
    if (!ld || md == 2'd0 || md == 2'd3) return d;
    if (md == 2'd1) return x;
    y = 8'h00;
    for (int i = 0; i < 8; i++) y[i] = x[perm_src[i]];
    return y;
  endfunction

  // One clock: check in_ready, predict the edge, then compare all outputs after it.
  task automatic tick(input string tag);
    logic       acc;
    logic [7:0] res;
    #1;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
    acc = bus.in_valid && (!m_valid || bus.out_ready);
    res = ref_decrypt(mode, m_loaded, bus.in_m1, bus.in_addr, bus.in_data);
    @(posedge clk);
    #1;
    if (reset) begin
      for (int k = 0; k < 8; k++) m_key[k] = 8'h00;
      m_cnt = 0; m_loaded = 1'b0; m_valid = 1'b0; m_data = 8'h00;
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        m_data  = res;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (dn_start) m_cnt = dn_wr ? 1 : 0;
      else if (dn_wr && m_cnt < 8) m_cnt++;
      if (dn_wr) m_key[dn_addr] = dn_data;
      m_loaded = (m_cnt == 8);
    end
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, " out_data"},  32'(bus.out_data),  32'(m_data));
    check({tag, " loaded"},    32'(loaded),        32'(m_loaded));
  endtask

  task automatic idle();
    reset = 1'b0; dn_start = 1'b0; dn_wr = 1'b0; dn_addr = 3'd0; dn_data = 8'h00;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic fetch1(input string name, input logic [1:0] md, input logic m1,
                        input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp);
    mode = md; bus.in_m1 = m1; bus.in_addr = a; bus.in_data = d;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick(name);
    check({name, " result"}, 32'(bus.out_data), 32'(exp));
    check({name, " valid"}, 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    tick(name);
  endtask

  task automatic download(input string name, input int nwrites);
    dn_start = 1'b1; tick(name); dn_start = 1'b0;
    for (int k = 0; k < nwrites; k++) begin
      dn_wr = 1'b1; dn_addr = dl_addrs[k]; dn_data = dl_vals[k];
      tick(name);
      if (k == 6) check({name, " loaded before 8th"}, 32'(loaded), 32'd0);
      if (k == 7) check({name, " loaded after 8th"}, 32'(loaded), 32'd1);
    end
    dn_wr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'd0, 1'b1, 16'h2004, 8'h5A, 8'h5A};
    vecs[1]  = '{2'd3, 1'b0, 16'h0000, 8'h77, 8'h77};
    vecs[2]  = '{2'd1, 1'b0, 16'h0000, 8'hF0, 8'hF1};
    vecs[3]  = '{2'd1, 1'b0, 16'h0004, 8'h00, 8'h02};
    vecs[4]  = '{2'd1, 1'b0, 16'h2000, 8'h0F, 8'h0B};
    vecs[5]  = '{2'd1, 1'b1, 16'h2004, 8'h80, 8'h00};
    vecs[6]  = '{2'd2, 1'b1, 16'h0000, 8'h00, 8'h02};
    vecs[7]  = '{2'd2, 1'b0, 16'h0004, 8'h00, 8'h10};
    vecs[8]  = '{2'd2, 1'b1, 16'h2000, 8'h00, 8'h04};
    vecs[9]  = '{2'd2, 1'b0, 16'h0000, 8'hFF, 8'hFE};
    vecs[10] = '{2'd2, 1'b1, 16'h0004, 8'h00, 8'h20};
    vecs[11] = '{2'd2, 1'b0, 16'h2004, 8'h0C, 8'h40};

    for (int k = 0; k < 8; k++) begin
      m_key[k] = 8'h00; dl_addrs[k] = 3'(k);
    end
    m_cnt = 0; m_loaded = 1'b0; m_valid = 1'b0; m_data = 8'h00;
    idle();
    mode = 2'd0; bus.in_m1 = 1'b0; bus.in_addr = 16'h0000; bus.in_data = 8'h00;

    reset = 1'b1;
    tick("reset"); tick("reset");
    reset = 1'b0;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data",  32'(bus.out_data),  32'd0);
    check("reset loaded",    32'(loaded),        32'd0);

    fetch1("unloaded passthrough", 2'd2, 1'b0, 16'h0000, 8'hA5, 8'hA5);

    for (int k = 0; k < 8; k++) dl_vals[k] = 8'hFF;
    download("dl all FF", 8);
    fetch1("xor FF", 2'd1, 1'b1, 16'h1234, 8'h3C, 8'hC3);

    for (int k = 0; k < 8; k++) dl_vals[k] = (k == 4) ? 8'h81 : 8'h00;
    download("dl key4", 8);
    fetch1("perm key4", 2'd2, 1'b1, 16'h0000, 8'h00, 8'h81);

    for (int k = 0; k < 8; k++) dl_vals[k] = 8'h01 << k;
    download("dl onehot", 8);
    for (int v = 0; v < 12; v++) begin
      fetch1($sformatf("vec%0d", v), vecs[v].md, vecs[v].m1, vecs[v].addr, vecs[v].data, vecs[v].exp);
    end

    // Write entry 2 while fetching through entry 2: old mask first, new mask next.
    mode = 2'd1; bus.in_m1 = 1'b0; bus.in_addr = 16'h2000; bus.in_data = 8'h00;
    bus.in_valid = 1'b1; dn_wr = 1'b1; dn_addr = 3'd2; dn_data = 8'hF0;
    tick("wr/rd collide");
    check("collide old mask", 32'(bus.out_data), 32'h04);
    dn_wr = 1'b0;
    tick("wr/rd next");
    check("collide new mask", 32'(bus.out_data), 32'hF0);
    check("collide loaded", 32'(loaded), 32'd1);
    bus.in_valid = 1'b0;
    tick("collide drain");

    // Backpressure: result held for three cycles, then back-to-back results in order.
    mode = 2'd1; bus.in_addr = 16'h0000; bus.in_m1 = 1'b0;
    bus.in_data = 8'h10; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick("stall first");
    check("stall first data", 32'(bus.out_data), 32'h11);
    bus.in_data = 8'h20; mode = 2'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      tick("stall hold");
      check($sformatf("stall%0d data", c), 32'(bus.out_data), 32'h11);
    end
    mode = 2'd1; bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = 8'(8'h20 + 8'(c) * 8'h10);
      tick("b2b");
      check($sformatf("b2b%0d data", c), 32'(bus.out_data), 32'(8'h21 + 8'(c) * 8'h10));
      check($sformatf("b2b%0d valid", c), 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick("drain");
    check("drain valid", 32'(bus.out_valid), 32'd0);
    check("drain data hold", 32'(bus.out_data), 32'h41);

    // Reset mid-download, with a write and a fetch colliding with the reset edge.
    for (int k = 0; k < 8; k++) dl_vals[k] = 8'hFF;
    dn_start = 1'b1; tick("partial"); dn_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dn_wr = 1'b1; dn_addr = 3'(k); dn_data = 8'hFF; tick("partial wr");
    end
    reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h99;
    tick("reset mid");
    reset = 1'b0; dn_wr = 1'b0; bus.in_valid = 1'b0;
    check("mid reset loaded", 32'(loaded), 32'd0);
    check("mid reset valid", 32'(bus.out_valid), 32'd0);
    tick("after reset");
    check("after reset loaded", 32'(loaded), 32'd0);
    for (int k = 0; k < 8; k++) begin
      dl_vals[k] = 8'h55; dl_addrs[k] = 3'd7;
    end
    download("dl entry7", 8);
    fetch1("cleared entry0", 2'd1, 1'b0, 16'h0000, 8'h3C, 8'h3C);
    for (int k = 0; k < 8; k++) dl_addrs[k] = 3'(k);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      dn_start     = ($urandom_range(0, 39) == 0);
      dn_wr        = ($urandom_range(0, 3) == 0);
      dn_addr      = 3'($urandom_range(0, 7));
      dn_data      = 8'($urandom);
      mode         = 2'($urandom_range(0, 3));
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_m1    = ($urandom_range(0, 1) == 1);
      bus.in_addr  = 16'($urandom);
      bus.in_data  = 8'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/opcode_decrypt_pipe.md
OPCODE_DECRYPT_PIPE -- requirements
Module: opcode_decrypt_pipe

Interface
REQ-001 Parameter DW, default 8: data width in bits.
REQ-002 Parameter AW, default 16: address width in bits.
REQ-003 Parameter BIT_A, default 13: address bit used as table index bit 1.
REQ-004 Parameter BIT_B, default 2: address bit used as table index bit 0.
REQ-005 Parameter PERM, default {3'd7,3'd2,3'd5,3'd1,3'd3,3'd6,3'd4,3'd0}: DW 3-bit source indices. Field i (MSB field = bit DW-1) selects the input bit driving output bit i.
REQ-006 clk  input  1  single clock; all logic is on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 mode  input  2  0 passthrough, 1 XOR only, 2 XOR then PERM, 3 treated as 0.
REQ-009 dn_start  input  1  one-cycle pulse that begins a key-table download.
REQ-010 dn_wr  input  1  key-table write strobe.
REQ-011 dn_addr  input  3  key-table entry index.
REQ-012 dn_data  input  DW  XOR mask written to the entry.
REQ-013 loaded  output  1  high once 8 writes have completed since the last dn_start.
REQ-014 in_valid  input  1  fetch request valid.
REQ-015 in_ready  output  1  block can accept a fetch this cycle.
REQ-016 in_addr  input  AW  fetch address.
REQ-017 in_data  input  DW  raw ROM byte.
REQ-018 in_m1  input  1  opcode fetch (1) or operand/data read (0).
REQ-019 out_valid  output  1  out_data holds a result.
REQ-020 out_ready  input  1  consumer accepts the result.
REQ-021 out_data  output  DW  decrypted byte.

Function
REQ-022 The key table SHALL hold 8 entries of DW bits, indexed by idx = {in_m1, in_addr[BIT_A], in_addr[BIT_B]}.
REQ-023 Entry write: dn_wr=1 SHALL write dn_data to entry dn_addr at the clock edge.
REQ-024 Write counter: a 4-bit counter SHALL increment on each dn_wr, saturating at 8.
REQ-025 dn_start SHALL clear the counter and deassert loaded; table contents are retained.
REQ-026 dn_start and dn_wr in the same cycle: the write SHALL apply and the counter SHALL become 1.
REQ-027 loaded SHALL be registered and assert the cycle after the counter reaches 8.
REQ-028 While loaded=0, the effective mode SHALL be 0.
REQ-029 mode SHALL be sampled at the accept edge together with the fetch; a mode change never alters a result already held.
REQ-030 Effective mode 1: result SHALL be in_data XOR table[idx].
REQ-031 Effective mode 2: result bit i SHALL be x[PERM field i], where x = in_data XOR table[idx].
REQ-032 Handshake: in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-033 Accept occurs when in_valid && in_ready; out_data SHALL update and out_valid SHALL go 1 at that edge, giving 1-cycle latency.
REQ-034 Accept with out_valid=1 and out_ready=1 SHALL replace the result in place, sustaining 1 result per cycle.
REQ-035 out_valid=1, out_ready=1, in_valid=0: out_valid SHALL clear and out_data SHALL hold its last value.
REQ-036 out_valid=1, out_ready=0: out_data SHALL remain stable and no fetch SHALL be accepted.
REQ-037 Table write and lookup of the same entry in the same cycle: the lookup SHALL use the old entry value.
REQ-038 dn_addr values are always in range; no error signalling.

Reset
REQ-039 On reset=1: out_valid=0, out_data=0, loaded=0, write counter=0, all 8 table entries=0; takes priority over dn_start, dn_wr and accept in the same cycle.
REQ-040 Reset asserted mid-download SHALL discard partial progress; a new dn_start plus 8 writes is required before loaded asserts.

Verification
REQ-041 Reset, then mode=2 with no download, fetch data=8'hA5 -> out_data=8'hA5 one cycle later (forced passthrough).
REQ-042 dn_start, write table[k]=8'hFF for k=0..7 -> loaded=1 the cycle after the 8th write; mode=1, fetch data=8'h3C -> out_data=8'hC3.
REQ-043 Table[4]=8'h81 (others 0), mode=2, m1=1, addr=16'h0000, data=8'h00 -> x=8'h81, out_data=8'h81 under the default PERM.
REQ-044 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_data stable; release -> back-to-back results, one per cycle, in order.
REQ-045 dn_wr to entry 2 in the same cycle as a fetch indexing entry 2 -> result uses the old mask; the next fetch uses the new mask.
REQ-046 Reset after 5 of 8 writes -> loaded stays 0 and the table reads 0; dn_start plus 8 writes -> loaded=1.
